// File: rtl/gpc_decomp_3__5.sv
`default_nettype none
// ============================================================================
// Module      : gpc_decomp_3__5
// Description : Turns a 3-bit GPC sum (0..7) into a stream of column tokens.
//               Weight-2 tokens come from column 1 and weight-1 tokens from
//               column 0. A zero value yields one weightless token.
//               The canonical column pattern is held on pat.
// Revision    : 1.0 - initial release
// ============================================================================
module gpc_decomp_3__5 #(
    parameter bit HI_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_v,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_w,
    output logic       out_last,
    output logic       out_zero,
    output logic [4:0] pat,
    output logic       busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state;
    // Tokens still owed after the one currently presented
    logic [1:0] rem1;
    logic [1:0] rem0;

    logic       accept;
    logic       advance;
    logic [1:0] c1;
    logic [1:0] c0;
    logic [4:0] pat_new;
    logic       is_zero;
    logic [1:0] src1;
    logic [1:0] src0;
    logic       take_hi;
    logic       nxt_w;
    logic       nxt_last;
    logic [1:0] nxt_rem1;
    logic [1:0] nxt_rem0;

    assign in_ready = (state == IDLE);
    assign busy     = (state == EMIT);
    assign accept   = in_valid & in_ready;
    assign advance  = out_valid & out_ready;

    // Column split: values 4..7 saturate c1 at 2 and leave the low two bits in c0
    assign c1      = in_v[2] ? 2'd2 : {1'b0, in_v[1]};
    assign c0      = in_v[2] ? in_v[1:0] : {1'b0, in_v[0]};
    assign is_zero = (in_v == 3'd0);

    // Thermometer codes, LSB first: c1 in bits [4:3], c0 in bits [2:0]
    assign pat_new = {c1[1], (c1 != 2'd0), (c0 == 2'd3), c0[1], (c0 != 2'd0)};

    // Pick the next token from either the freshly split value or the remaining counts
    always_comb begin
        src1     = accept ? c1 : rem1;
        src0     = accept ? c0 : rem0;
        take_hi  = HI_FIRST ? (src1 != 2'd0) : (src0 == 2'd0);
        nxt_w    = take_hi;
        nxt_rem1 = take_hi ? (src1 - 2'd1) : src1;
        nxt_rem0 = take_hi ? src0 : (src0 - 2'd1);
        nxt_last = (nxt_rem1 == 2'd0) && (nxt_rem0 == 2'd0);
        if (accept && is_zero) begin
            nxt_w    = 1'b0;
            nxt_rem1 = 2'd0;
            nxt_rem0 = 2'd0;
            nxt_last = 1'b1;
        end
    end

    // Control FSM with registered token outputs; reset overrides any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rem1      <= 2'd0;
            rem0      <= 2'd0;
            out_valid <= 1'b0;
            out_w     <= 1'b0;
            out_last  <= 1'b0;
            out_zero  <= 1'b0;
            pat       <= 5'b00000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= EMIT;
                        pat       <= pat_new;
                        out_valid <= 1'b1;
                        out_w     <= nxt_w;
                        out_last  <= nxt_last;
                        out_zero  <= is_zero;
                        rem1      <= nxt_rem1;
                        rem0      <= nxt_rem0;
                    end
                end
                EMIT: begin
                    if (advance) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_w     <= 1'b0;
                            out_last  <= 1'b0;
                            out_zero  <= 1'b0;
                            rem1      <= 2'd0;
                            rem0      <= 2'd0;
                        end else begin
                            out_w    <= nxt_w;
                            out_last <= nxt_last;
                            rem1     <= nxt_rem1;
                            rem0     <= nxt_rem0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpc_decomp_3__5.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpc_decomp_3__5
// Description : Scoreboard bench for gpc_decomp_3__5, one instance per
//               token ordering.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpc_decomp_3__5;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid_h, in_valid_l;
    logic [2:0] in_v_h, in_v_l;
    logic       in_ready_h, in_ready_l;
    logic       out_valid_h, out_valid_l;
    logic       out_ready_h, out_ready_l;
    logic       out_w_h, out_w_l, out_last_h, out_last_l, out_zero_h, out_zero_l;
    logic [4:0] pat_h, pat_l;
    logic       busy_h, busy_l;

    always #5 clk = ~clk;

    gpc_decomp_3__5 #(.HI_FIRST(1'b1)) dut_h (
        .clk(clk), .rst(rst), .in_valid(in_valid_h), .in_ready(in_ready_h), .in_v(in_v_h),
        .out_valid(out_valid_h), .out_ready(out_ready_h), .out_w(out_w_h),
        .out_last(out_last_h), .out_zero(out_zero_h), .pat(pat_h), .busy(busy_h)
    );

    gpc_decomp_3__5 #(.HI_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_valid(in_valid_l), .in_ready(in_ready_l), .in_v(in_v_l),
        .out_valid(out_valid_l), .out_ready(out_ready_l), .out_w(out_w_l),
        .out_last(out_last_l), .out_zero(out_zero_l), .pat(pat_l), .busy(busy_l)
    );

    // Hand-computed tables indexed by in_v
    localparam logic [4:0] PAT_T [0:7] = '{5'b00000, 5'b00001, 5'b01000, 5'b01001,
                                           5'b11000, 5'b11001, 5'b11011, 5'b11111};
    localparam int         N_T   [0:7] = '{1, 1, 1, 2, 2, 3, 4, 5};
    // Token weights in emission order, bit i = token i
    localparam logic [4:0] WH_T  [0:7] = '{5'b00000, 5'b00000, 5'b00001, 5'b00001,
                                           5'b00011, 5'b00011, 5'b00011, 5'b00011};
    localparam logic [4:0] WL_T  [0:7] = '{5'b00000, 5'b00000, 5'b00001, 5'b00010,
                                           5'b00011, 5'b00110, 5'b01100, 5'b11000};

    typedef struct packed {
        logic       w;
        logic       last;
        logic       zero;
        logic [4:0] pat;
        logic [2:0] v;
    } tok_t;

    tok_t q_h[$];
    tok_t q_l[$];
    int   total = 0;
    int   bad   = 0;
    int   bp_mode = 0;   // 0 ready, 1 pattern 1,0,0,1, 2 random, 3 stalled

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // Output-ready driver for the HI_FIRST instance
    initial begin
        int ph;
        logic [3:0] patt;
        ph          = 0;
        patt        = 4'b1001;
        out_ready_h = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0: out_ready_h = 1'b1;
                1: begin out_ready_h = patt[3 - ph]; ph = (ph + 1) % 4; end
                2: out_ready_h = 1'($urandom_range(0, 1));
                default: out_ready_h = 1'b0;
            endcase
        end
    end

    // Monitor state, index 0 = HI_FIRST instance, 1 = weight-1-first instance
    int         wsum  [2] = '{0, 0};
    bit         stall [2] = '{0, 0};
    bit         rstp  [2] = '{0, 0};
    logic [2:0] held  [2];

    task automatic mon(input bit lo);
        logic ov, ordy, w, last, zero;
        logic [4:0] p;
        tok_t e;
        if (lo) begin
            ov = out_valid_l; ordy = out_ready_l; w = out_w_l;
            last = out_last_l; zero = out_zero_l; p = pat_l;
        end else begin
            ov = out_valid_h; ordy = out_ready_h; w = out_w_h;
            last = out_last_h; zero = out_zero_h; p = pat_h;
        end
        if (stall[lo] && !rstp[lo]) begin
            chk(lo ? "hold_valid_l" : "hold_valid_h", ov, 1);
            chk(lo ? "hold_tok_l" : "hold_tok_h", {w, last, zero}, held[lo]);
        end
        if (ov && ordy) begin
            if ((lo ? q_l.size() : q_h.size()) == 0) begin
                chk(lo ? "unexpected_tok_l" : "unexpected_tok_h", 1, 0);
            end else begin
                e = lo ? q_l.pop_front() : q_h.pop_front();
                chk(lo ? "tok_w_l" : "tok_w_h", w, e.w);
                chk(lo ? "tok_last_l" : "tok_last_h", last, e.last);
                chk(lo ? "tok_zero_l" : "tok_zero_h", zero, e.zero);
                chk(lo ? "tok_pat_l" : "tok_pat_h", p, e.pat);
                wsum[lo] += zero ? 0 : (w ? 2 : 1);
                if (last) begin
                    chk(lo ? "wsum_l" : "wsum_h", wsum[lo], e.v);
                    wsum[lo] = 0;
                end
            end
        end
        stall[lo] = ov && !ordy;
        held[lo]  = {w, last, zero};
        rstp[lo]  = rst;
        if (rst) wsum[lo] = 0;
    endtask

    always @(negedge clk) mon(1'b0);
    always @(negedge clk) mon(1'b1);

    task automatic send(input bit lo, input int v);
        bit   ok;
        tok_t t;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (lo ? in_ready_l : in_ready_h) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < N_T[v]; i++) begin
            t.w    = lo ? WL_T[v][i] : WH_T[v][i];
            t.last = (i == N_T[v] - 1);
            t.zero = (v == 0);
            t.pat  = PAT_T[v];
            t.v    = 3'(v);
            if (lo) q_l.push_back(t); else q_h.push_back(t);
        end
        if (lo) begin in_valid_l = 1'b1; in_v_l = 3'(v); end
        else    begin in_valid_h = 1'b1; in_v_h = 3'(v); end
        @(posedge clk);
        #1;
        in_valid_l = 1'b0;
        in_valid_h = 1'b0;
        @(negedge clk);
        chk("latency_valid", lo ? out_valid_l : out_valid_h, 1);
        chk("busy_emit",     lo ? busy_l : busy_h, 1);
        chk("in_ready_emit", lo ? in_ready_l : in_ready_h, 0);
        chk("pat_accept",    lo ? pat_l : pat_h, PAT_T[v]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int v;
        rst = 1'b1;
        in_valid_h = 1'b0; in_valid_l = 1'b0;
        in_v_h = 3'd0; in_v_l = 3'd0;
        out_ready_l = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid_h, 0);
        chk("rst_in_ready",  in_ready_h, 1);
        chk("rst_busy",      busy_h, 0);
        chk("rst_pat",       pat_h, 0);
        chk("rst_tok",       {out_w_h, out_last_h, out_zero_h}, 0);
        chk("rst_in_ready_l", in_ready_l, 1);

        // in_v=7, full throughput: five tokens, in_ready back one cycle after the last
        send(1'b0, 7);
        repeat (4) @(negedge clk);
        chk("v7_last_flag", out_last_h, 1);
        chk("v7_in_ready_busy", in_ready_h, 0);
        @(negedge clk);
        chk("v7_in_ready_after", in_ready_h, 1);
        chk("v7_idle_valid", out_valid_h, 0);
        chk("v7_idle_tok", {out_w_h, out_last_h, out_zero_h}, 0);

        // Weight-1-first ordering
        send(1'b1, 3);
        send(1'b1, 7);
        send(1'b1, 0);
        send(1'b1, 5);

        // Zero value and small values
        send(1'b0, 0);
        send(1'b0, 1);
        send(1'b0, 2);

        // Stalls with out_ready pattern 1,0,0,1
        bp_mode = 1;
        send(1'b0, 6);
        bp_mode = 0;

        // Reset after the first token of in_v=4
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready_h) begin ok = 1'b1; break; end
        end
        chk("rst_test_ready", ok, 1);
        q_h.push_back('{w: 1'b1, last: 1'b0, zero: 1'b0, pat: 5'b11000, v: 3'd4});
        in_valid_h = 1'b1; in_v_h = 3'd4;
        @(posedge clk);
        #1 in_valid_h = 1'b0;
        @(negedge clk);
        bp_mode = 3;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", out_valid_h, 0);
        chk("abort_in_ready",  in_ready_h, 1);
        chk("abort_pat",       pat_h, 0);
        chk("abort_busy",      busy_h, 0);
        bp_mode = 0;
        send(1'b0, 2);

        // Sweep with random backpressure
        bp_mode = 2;
        for (int i = 0; i < 24; i++) begin
            v = (i < 8) ? i : int'($urandom_range(0, 7));
            send(1'b0, v);
        end
        bp_mode = 0;

        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q_h.size() == 0 && q_l.size() == 0 && in_ready_h && in_ready_l) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_done", ok, 1);
        chk("q_h_empty", q_h.size(), 0);
        chk("q_l_empty", q_l.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpc_decomp_3__5.md
GPC_DECOMP_3__5 -- requirements
Module: gpc_decomp_3__5

Interface
REQ-001 SHALL have parameter HI_FIRST, default 1; 1 = weight-2 tokens are emitted before weight-1 tokens, 0 = weight-1 tokens first.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  in_v is valid this cycle.
REQ-005 SHALL have port in_ready  output  1  block can accept a value this cycle.
REQ-006 SHALL have port in_v  input  3  binary count 0..7 to decompress (the 3-bit sum a (2,3) GPC produces).
REQ-007 SHALL have port out_valid  output  1  a token is presented.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the token.
REQ-009 SHALL have port out_w  output  1  token weight: 0 = weight 1 (column 0), 1 = weight 2 (column 1).
REQ-010 SHALL have port out_last  output  1  final token of the current value.
REQ-011 SHALL have port out_zero  output  1  value was 0; the token carries no weight.
REQ-012 SHALL have port pat  output  5  canonical column pattern {a4,a3,a2,a1,a0}, held from accept until the next accept.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE and EMIT.
REQ-015 SHALL assert in_ready only in IDLE; a value is accepted on the cycle when in_valid and in_ready are both high.
REQ-016 On accept, SHALL compute c1 = min(2, in_v>>1) and c0 = in_v - 2*c1 (c0 range 0..3), and SHALL register both.
REQ-017 On accept, SHALL set pat[2:0] to a thermometer code of c0 (LSB first) and pat[4:3] to a thermometer code of c1; for example, in_v=5 gives pat=5'b11001.
REQ-018 SHALL move from IDLE to EMIT on accept; out_valid SHALL first be high in the cycle after accept (latency 1).
REQ-019 In EMIT, SHALL present c1+c0 tokens in total: c1 tokens with out_w=1 and c0 tokens with out_w=0, ordered as HI_FIRST selects.
REQ-020 For in_v=0, SHALL present exactly one token with out_zero=1, out_w=0 and out_last=1.
REQ-021 SHALL hold each token (out_w, out_last, out_zero) stable while out_valid=1 and out_ready=0; SHALL advance to the next token only when out_valid and out_ready are both high.
REQ-022 SHALL assert out_last on the final token only; when that token is accepted the FSM SHALL return to IDLE, and in_ready SHALL go high in the following cycle (no same-cycle accept).
REQ-023 The sum of weights over the emitted tokens SHALL equal the accepted in_v.
REQ-024 SHALL ignore in_valid and in_v while in EMIT.
REQ-025 out_valid, out_last, out_zero and out_w SHALL be 0 while in IDLE.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, out_valid=0, out_w=0, out_last=0, out_zero=0, pat=5'b00000, busy=0 and clear all counters; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-027 rst asserted during EMIT SHALL abort the value at once; remaining tokens SHALL be discarded, and no token SHALL appear after reset.
REQ-028 rst SHALL take priority over a simultaneous input accept or output handshake in the same cycle.

Verification
REQ-029 HI_FIRST=1, in_v=7, out_ready=1 -> pat=11111; tokens w=1,1,0,0,0 on consecutive cycles; out_last on the 5th token; in_ready high 1 cycle after the 5th token.
REQ-030 HI_FIRST=0, in_v=3 -> pat=01001; tokens w=0 then w=1 (last).
REQ-031 in_v=0 -> pat=00000; one token with out_zero=1 and out_last=1; the FSM returns to IDLE.
REQ-032 in_v=6, out_ready toggled 1,0,0,1,... -> each token held while stalled; sequence 1,1,0,0 with no loss or duplication; weight sum 6.
REQ-033 in_v=4 accepted, rst pulsed after the first token -> out_valid=0 in the cycle after rst; in_ready=1 and pat=00000 after rst deasserts; a new in_v=2 then yields a single token w=1 (last).
REQ-034 Random sweep over in_v 0..7 with random out_ready backpressure -> for every value, the weight sum equals in_v, exactly one out_last per value, and pat matches REQ-017.
